// File: rtl/lcd_pkg.sv
// ============================================================================
// Module      : lcd_pkg
// Description : HD44780 command constants, controller/bus state encodings and
//               the DDRAM line-base helper shared by the LCD text controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lcd_pkg;

    // HD44780 8-bit-mode instruction bytes
    localparam logic [7:0] c_cmd_init    = 8'h30;  // function set, 8-bit, wake-up
    localparam logic [7:0] c_cmd_func_2l = 8'h38;  // function set, 8-bit, 2-line
    localparam logic [7:0] c_cmd_doff    = 8'h08;  // display off
    localparam logic [7:0] c_cmd_clr     = 8'h01;  // clear display
    localparam logic [7:0] c_cmd_entry   = 8'h06;  // increment, no shift
    localparam logic [7:0] c_cmd_don     = 8'h0C;  // display on, cursor off
    localparam logic [7:0] c_ddram_l0    = 8'h80;  // set DDRAM address, row 0
    localparam logic [7:0] c_ddram_l1    = 8'hC0;  // set DDRAM address, row 1

    // Sequencer states
    typedef enum logic [3:0] {
        S_POR      = 4'd0,
        S_INIT     = 4'd1,
        S_FUNC     = 4'd2,
        S_DOFF     = 4'd3,
        S_CLR      = 4'd4,
        S_ENTRY    = 4'd5,
        S_DON      = 4'd6,
        S_IDLE     = 4'd7,
        S_LINE_CMD = 4'd8,
        S_LINE_WR  = 4'd9
    } lcd_state_e;

    // Phases of a single bus write
    typedef enum logic [1:0] {
        PH_IDLE  = 2'd0,
        PH_SETUP = 2'd1,
        PH_HIGH  = 2'd2,
        PH_POST  = 2'd3
    } xfer_phase_e;

    // Lines 2 and 3 of a 4-line panel continue rows 0 and 1 after NUM_COLS chars
    function automatic logic [7:0] line_base(input logic [1:0] line, input int unsigned ncols);
        logic [7:0] cols8;
        cols8 = 8'(ncols);
        case (line)
            2'd0:    return c_ddram_l0;
            2'd1:    return c_ddram_l1;
            2'd2:    return c_ddram_l0 + cols8;
            default: return c_ddram_l1 + cols8;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_bus_xfer.sv
// ============================================================================
// Module      : lcd_bus_xfer
// Description : One HD44780 write cycle: latch rs/data, hold for the setup
//               time, pulse E, then wait the per-command post delay.
//               rs/data stay on the pins until the next write.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_bus_xfer
    import lcd_pkg::*;
#(
    parameter int E_SETUP_CYC = 4,
    parameter int E_HIGH_CYC  = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        rs_i,
    input  logic [7:0]  data_i,
    input  logic [31:0] post_wait_i,
    output logic        lcd_e_o,
    output logic        lcd_rs_o,
    output logic [7:0]  lcd_data_o,
    output logic        busy_o,
    output logic        done_o
);

    xfer_phase_e phase_q;
    logic [31:0] cnt_q;
    logic        e_q;
    logic        rs_q;
    logic [7:0]  data_q;
    logic        busy_q;
    logic        done_q;

    // Phase sequencer: setup -> E high -> post wait -> one-cycle done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= PH_IDLE;
            cnt_q   <= '0;
            e_q     <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (phase_q)
                PH_IDLE: begin
                    if (start_i) begin
                        rs_q    <= rs_i;
                        data_q  <= data_i;
                        busy_q  <= 1'b1;
                        cnt_q   <= 32'(E_SETUP_CYC - 1);
                        phase_q <= PH_SETUP;
                    end
                end
                PH_SETUP: begin
                    if (cnt_q == 32'd0) begin
                        e_q     <= 1'b1;
                        cnt_q   <= 32'(E_HIGH_CYC - 1);
                        phase_q <= PH_HIGH;
                    end else begin
                        cnt_q <= cnt_q - 32'd1;
                    end
                end
                PH_HIGH: begin
                    if (cnt_q == 32'd0) begin
                        e_q     <= 1'b0;
                        cnt_q   <= post_wait_i - 32'd1;
                        phase_q <= PH_POST;
                    end else begin
                        cnt_q <= cnt_q - 32'd1;
                    end
                end
                default: begin
                    if (cnt_q == 32'd0) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        phase_q <= PH_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 32'd1;
                    end
                end
            endcase
        end
    end

    assign lcd_e_o    = e_q;
    assign lcd_rs_o   = rs_q;
    assign lcd_data_o = data_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule

`default_nettype wire

// File: rtl/lcd_text_ctrl.sv
// ============================================================================
// Module      : lcd_text_ctrl
// Description : HD44780 character-LCD controller, 8-bit write-only mode.
//               Holds a NUM_LINES x NUM_COLS text buffer, runs power-on init,
//               then streams buffer lines to the panel.
// Options     : LCD_DIRTY_EN - when defined, only lines written since their
//               last transfer are resent; otherwise all lines refresh
//               continuously in order.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lcd_text_ctrl
    import lcd_pkg::*;
#(
    parameter int NUM_LINES     = 2,
    parameter int NUM_COLS      = 16,
    parameter int POR_WAIT_CYC  = 2_000_000,
    parameter int INIT_WAIT_CYC = 250_000,
    parameter int CMD_WAIT_CYC  = 2_500,
    parameter int CLR_WAIT_CYC  = 100_000,
    parameter int E_SETUP_CYC   = 4,
    parameter int E_HIGH_CYC    = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [1:0] wr_line,
    input  logic [4:0] wr_col,
    input  logic [7:0] wr_char,
    output logic       ready,
    output logic       busy,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_data
);

    localparam int         NCHARS      = NUM_LINES * NUM_COLS;
    localparam int         AW          = $clog2(NCHARS);
    localparam logic [2:0] c_num_lines = 3'(NUM_LINES);
    localparam logic [5:0] c_num_cols  = 6'(NUM_COLS);

    generate
        if (!(NUM_LINES == 1 || NUM_LINES == 2 || NUM_LINES == 4)) begin : g_bad_lines
            $error("lcd_text_ctrl: NUM_LINES must be 1, 2 or 4");
        end
        if (NUM_COLS < 8 || NUM_COLS > 20) begin : g_bad_cols
            $error("lcd_text_ctrl: NUM_COLS must be 8..20");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Text buffer, flattened line-major
    // ------------------------------------------------------------------
    logic [7:0]    buf_q [NCHARS];
    logic          w_wr_valid;
    logic [AW-1:0] w_wr_idx;
    logic [AW-1:0] w_rd_idx;

    logic [1:0]    line_q;
    logic [4:0]    col_q;

    assign w_wr_valid = wr_en && ({1'b0, wr_line} < c_num_lines) && ({1'b0, wr_col} < c_num_cols);
    assign w_wr_idx   = AW'(32'(wr_line) * 32'(NUM_COLS) + 32'(wr_col));
    assign w_rd_idx   = AW'(32'(line_q) * 32'(NUM_COLS) + 32'(col_q));

    // Buffer write port: one character per cycle, out-of-range writes dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NCHARS; i++) begin
                buf_q[i] <= 8'h20;
            end
        end else if (w_wr_valid) begin
            buf_q[w_wr_idx] <= wr_char;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    lcd_state_e  state_q;
    logic        issued_q;
    logic [1:0]  init_cnt_q;
    logic [31:0] timer_q;
    logic [1:0]  last_line_q;
    logic        ready_q;
    logic        start_q;
    logic        rs_q;
    logic [7:0]  data_q;
    logic [31:0] post_wait_q;
    logic        w_done;

    // ------------------------------------------------------------------
    // Next-line selection
    // ------------------------------------------------------------------
    logic       w_next_found;
    logic [1:0] w_next_line;

`ifdef LCD_DIRTY_EN
    logic [NUM_LINES-1:0] dirty_q;
    logic [NUM_LINES-1:0] w_dirty_set;
    logic [NUM_LINES-1:0] w_dirty_clr;
    logic [3:0]           w_dirty4;

    assign w_dirty_set = w_wr_valid ? NUM_LINES'(4'b0001 << wr_line) : '0;
    assign w_dirty_clr = (state_q == S_LINE_CMD && !issued_q) ? NUM_LINES'(4'b0001 << line_q) : '0;
    assign w_dirty4    = 4'(dirty_q);

    // Dirty flags: a write in the same cycle as the clear keeps the line dirty
    always_ff @(posedge clk) begin
        if (rst) begin
            dirty_q <= '1;
        end else begin
            dirty_q <= (dirty_q & ~w_dirty_clr) | w_dirty_set;
        end
    end

    // Round-robin search among dirty lines, starting after the last one sent
    always_comb begin
        logic [1:0] cand;
        cand         = 2'd0;
        w_next_found = 1'b0;
        w_next_line  = 2'd0;
        for (int k = 1; k <= NUM_LINES; k++) begin
            cand = 2'((32'(last_line_q) + 32'(k)) % 32'(NUM_LINES));
            if (!w_next_found && w_dirty4[cand]) begin
                w_next_found = 1'b1;
                w_next_line  = cand;
            end
        end
    end
`else
    // Continuous refresh: always the line after the last one sent
    always_comb begin
        w_next_found = 1'b1;
        w_next_line  = (last_line_q == 2'(NUM_LINES - 1)) ? 2'd0 : last_line_q + 2'd1;
    end
`endif

    // ------------------------------------------------------------------
    // Per-state command byte, register select, post wait and successor
    // ------------------------------------------------------------------
    logic        w_cmd_rs;
    logic [7:0]  w_cmd_data;
    logic [31:0] w_cmd_wait;
    lcd_state_e  w_cmd_next;

    // Decode what the current command state puts on the bus
    always_comb begin
        w_cmd_rs   = 1'b0;
        w_cmd_data = c_cmd_init;
        w_cmd_wait = 32'(CMD_WAIT_CYC);
        w_cmd_next = state_q;
        case (state_q)
            S_INIT: begin
                w_cmd_wait = 32'(INIT_WAIT_CYC);
                w_cmd_next = (init_cnt_q == 2'd2) ? S_FUNC : S_INIT;
            end
            S_FUNC: begin
                w_cmd_data = (NUM_LINES > 1) ? c_cmd_func_2l : c_cmd_init;
                w_cmd_next = S_DOFF;
            end
            S_DOFF: begin
                w_cmd_data = c_cmd_doff;
                w_cmd_next = S_CLR;
            end
            S_CLR: begin
                w_cmd_data = c_cmd_clr;
                w_cmd_wait = 32'(CLR_WAIT_CYC);
                w_cmd_next = S_ENTRY;
            end
            S_ENTRY: begin
                w_cmd_data = c_cmd_entry;
                w_cmd_next = S_DON;
            end
            S_DON: begin
                w_cmd_data = c_cmd_don;
                w_cmd_next = S_IDLE;
            end
            S_LINE_CMD: begin
                w_cmd_data = line_base(line_q, NUM_COLS);
                w_cmd_next = S_LINE_WR;
            end
            S_LINE_WR: begin
                w_cmd_rs   = 1'b1;
                w_cmd_data = buf_q[w_rd_idx];
                w_cmd_next = (col_q == 5'(NUM_COLS - 1)) ? S_IDLE : S_LINE_WR;
            end
            default: ;
        endcase
    end

    // Main sequencer: power-on wait, init commands, then line streaming
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_POR;
            issued_q    <= 1'b0;
            init_cnt_q  <= 2'd0;
            timer_q     <= 32'd0;
            line_q      <= 2'd0;
            last_line_q <= 2'(NUM_LINES - 1);
            col_q       <= 5'd0;
            ready_q     <= 1'b0;
            start_q     <= 1'b0;
            rs_q        <= 1'b0;
            data_q      <= 8'h00;
            post_wait_q <= 32'd0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                S_POR: begin
                    if (timer_q == 32'(POR_WAIT_CYC - 1)) begin
                        timer_q <= 32'd0;
                        state_q <= S_INIT;
                    end else begin
                        timer_q <= timer_q + 32'd1;
                    end
                end
                S_IDLE: begin
                    if (w_next_found) begin
                        line_q      <= w_next_line;
                        last_line_q <= w_next_line;
                        col_q       <= 5'd0;
                        state_q     <= S_LINE_CMD;
                    end
                end
                default: begin
                    if (!issued_q) begin
                        start_q     <= 1'b1;
                        rs_q        <= w_cmd_rs;
                        data_q      <= w_cmd_data;
                        post_wait_q <= w_cmd_wait;
                        issued_q    <= 1'b1;
                    end else if (w_done) begin
                        issued_q <= 1'b0;
                        state_q  <= w_cmd_next;
                        if (state_q == S_INIT) begin
                            init_cnt_q <= init_cnt_q + 2'd1;
                        end
                        if (state_q == S_DON) begin
                            ready_q <= 1'b1;
                        end
                        if (state_q == S_LINE_WR) begin
                            col_q <= col_q + 5'd1;
                        end
                    end
                end
            endcase
        end
    end

    lcd_bus_xfer #(
        .E_SETUP_CYC (E_SETUP_CYC),
        .E_HIGH_CYC  (E_HIGH_CYC)
    ) u_bus (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_q),
        .rs_i        (rs_q),
        .data_i      (data_q),
        .post_wait_i (post_wait_q),
        .lcd_e_o     (lcd_e),
        .lcd_rs_o    (lcd_rs),
        .lcd_data_o  (lcd_data),
        .busy_o      (busy),
        .done_o      (w_done)
    );

    assign ready  = ready_q;
    assign lcd_rw = 1'b0;

endmodule

`default_nettype wire
